// File: rtl/aes_round_seq.sv
// aes_round_seq: iterative AES-128 encryption sequencer.
// Performs the initial AddRoundKey, then walks an external full-round datapath
// through round counts 0..8 and the last-round datapath for round count 9.
// Each round's result is fed back as the next round's state and key, and the
// ciphertext is presented on a valid/ready handshake.
// Optional feature macro: AES_SEQ_B2B_EN lets a new block be accepted in the
// same cycle as the ciphertext handshake, removing the dead cycle between blocks.

module aes_round_seq #(
   parameter int ROUND_LAT = 3,
   parameter int LAST_LAT  = 2,
   parameter int CNT_W     = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] pt,
   input  logic [127:0] key,
   output logic [127:0] rd_state,
   output logic [127:0] rd_key,
   output logic [3:0]   rd_rcnt,
   output logic         rd_last,
   input  logic [127:0] rnd_e,
   input  logic [127:0] rnd_keyout,
   input  logic [127:0] last_f,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ct,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      LAST,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] ROUND_END = CNT_W'(ROUND_LAT);
   localparam logic [CNT_W-1:0] LAST_END  = CNT_W'(LAST_LAT);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] wcnt;
   logic [CNT_W-1:0] wcnt_next;
   logic [127:0]     rd_state_next;
   logic [127:0]     rd_key_next;
   logic [3:0]       rd_rcnt_next;
   logic             rd_last_next;
   logic [127:0]     ct_next;
   logic             out_valid_next;
   logic             accept;
   logic             out_hs;

`ifdef AES_SEQ_B2B_EN
   // A new block may also enter while the finished one is being handed off.
   assign in_ready = ((state == IDLE) | ((state == DONE) & out_ready)) & ~rst;
`else
   // New blocks enter only from IDLE, so one dead cycle separates blocks.
   assign in_ready = (state == IDLE) & ~rst;
`endif

   assign accept = in_valid & in_ready;
   assign out_hs = out_valid & out_ready;
   assign busy   = (state == ROUND) | (state == LAST);

   // Next-state and datapath register updates; everything holds unless a
   // handshake or a capture cycle says otherwise.
   always_comb begin
      state_next     = state;
      wcnt_next      = wcnt;
      rd_state_next  = rd_state;
      rd_key_next    = rd_key;
      rd_rcnt_next   = rd_rcnt;
      rd_last_next   = rd_last;
      ct_next        = ct;
      out_valid_next = out_valid;
      case (state)
         IDLE: begin
            if (accept) begin
               rd_state_next = pt ^ key;
               rd_key_next   = key;
               rd_rcnt_next  = 4'd0;
               wcnt_next     = '0;
               state_next    = ROUND;
            end
         end
         ROUND: begin
            if (wcnt == ROUND_END) begin
               rd_state_next = rnd_e;
               rd_key_next   = rnd_keyout;
               rd_rcnt_next  = rd_rcnt + 4'd1;
               wcnt_next     = '0;
               if (rd_rcnt == 4'd8) begin
                  rd_last_next = 1'b1;
                  state_next   = LAST;
               end
            end else begin
               wcnt_next = wcnt + 1'b1;
            end
         end
         LAST: begin
            if (wcnt == LAST_END) begin
               ct_next        = last_f;
               out_valid_next = 1'b1;
               rd_last_next   = 1'b0;
               wcnt_next      = '0;
               state_next     = DONE;
            end else begin
               wcnt_next = wcnt + 1'b1;
            end
         end
         DONE: begin
            if (out_hs) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
            // Only reachable when back-to-back acceptance is enabled.
            if (accept) begin
               rd_state_next = pt ^ key;
               rd_key_next   = key;
               rd_rcnt_next  = 4'd0;
               wcnt_next     = '0;
               state_next    = ROUND;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= '0;
         rd_state  <= '0;
         rd_key    <= '0;
         rd_rcnt   <= 4'd0;
         rd_last   <= 1'b0;
         ct        <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         wcnt      <= wcnt_next;
         rd_state  <= rd_state_next;
         rd_key    <= rd_key_next;
         rd_rcnt   <= rd_rcnt_next;
         rd_last   <= rd_last_next;
         ct        <= ct_next;
         out_valid <= out_valid_next;
      end
   end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb_aes_round_seq: bench for the AES-128 round sequencer.
// Provides a latency-accurate round/last-round datapath (real AES or a simple
// arithmetic stub) and a timeline model of the sequencer outputs.
// Honours AES_SEQ_B2B_EN when the design is built with it.

module tb_aes_round_seq;

`ifdef AES_SEQ_B2B_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] pt;
   logic [127:0] key;
   logic [127:0] rd_state;
   logic [127:0] rd_key;
   logic [3:0]   rd_rcnt;
   logic         rd_last;
   logic [127:0] rnd_e = '0;
   logic [127:0] rnd_keyout = '0;
   logic [127:0] last_f = '0;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ct;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit started  = 1'b0;
   bit aes_mode = 1'b1;

   logic [7:0] sbox [256];

   aes_round_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pt         (pt),
      .key        (key),
      .rd_state   (rd_state),
      .rd_key     (rd_key),
      .rd_rcnt    (rd_rcnt),
      .rd_last    (rd_last),
      .rnd_e      (rnd_e),
      .rnd_keyout (rnd_keyout),
      .last_f     (last_f),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ct         (ct),
      .busy       (busy)
   );

   // Free-running clock and edge counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input int x);
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input int r);
      case (r)
         0: return 8'h01;
         1: return 8'h02;
         2: return 8'h04;
         3: return 8'h08;
         4: return 8'h10;
         5: return 8'h20;
         6: return 8'h40;
         7: return 8'h80;
         8: return 8'h1b;
         9: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[31:0];
      t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rcon(r), 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Datapath behaviour: real AES rounds or the arithmetic stub.
   function automatic logic [127:0] dp_key(input logic [127:0] k, input int r);
      return aes_mode ? next_key(k, r) : (k ^ 128'h1);
   endfunction

   function automatic logic [127:0] dp_full(input logic [127:0] s, input logic [127:0] k, input int r);
      return aes_mode ? (mix_columns(shift_rows(sub_bytes(s))) ^ next_key(k, r)) : (s + 128'h1);
   endfunction

   function automatic logic [127:0] dp_last(input logic [127:0] s, input logic [127:0] k);
      return aes_mode ? (shift_rows(sub_bytes(s)) ^ next_key(k, 9)) : (s ^ k);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // External datapath with latency: results appear only after the inputs
   // have been stable long enough; garbage is driven otherwise.
   logic [127:0] prev_s = '0;
   logic [127:0] prev_k = '0;
   logic [3:0]   prev_r = '0;
   logic         prev_l = 1'b0;
   int           stab   = 0;
   always @(posedge clk) begin
      #1;
      if (rd_state !== prev_s || rd_key !== prev_k || rd_rcnt !== prev_r || rd_last !== prev_l)
         stab = 0;
      else
         stab++;
      prev_s = rd_state;
      prev_k = rd_key;
      prev_r = rd_rcnt;
      prev_l = rd_last;
      if (!rd_last && stab >= 3) begin
         rnd_e      = dp_full(rd_state, rd_key, int'(rd_rcnt));
         rnd_keyout = dp_key(rd_key, int'(rd_rcnt));
      end else begin
         rnd_e      = rand128();
         rnd_keyout = rand128();
      end
      if (rd_last && stab >= 2) last_f = dp_last(rd_state, rd_key);
      else                      last_f = rand128();
   end

   // ---------------- Timeline model of the sequencer ----------------
   logic [127:0] st [10];
   logic [127:0] ky [10];
   logic [127:0] ct_exp;
   int           phase = 0;
   int           k_cnt = 0;
   logic [127:0] m_state = '0;
   logic [127:0] m_key = '0;
   logic [3:0]   m_rcnt = '0;
   logic         m_last = 1'b0;
   logic [127:0] m_ct = '0;
   logic         m_ov = 1'b0;

   task automatic model_accept(input logic [127:0] p, input logic [127:0] k);
      st[0] = p ^ k;
      ky[0] = k;
      for (int r = 0; r < 9; r++) begin
         st[r+1] = dp_full(st[r], ky[r], r);
         ky[r+1] = dp_key(ky[r], r);
      end
      ct_exp  = dp_last(st[9], ky[9]);
      phase   = 1;
      k_cnt   = 0;
      m_state = st[0];
      m_key   = ky[0];
      m_rcnt  = 4'd0;
   endtask

   // Compare every output against the model, then advance the model across
   // the upcoming rising edge using the inputs that edge will see.
   always @(negedge clk) begin
      if (started) begin
         logic exp_ready;
         exp_ready = !rst && (phase == 0 || (B2B && phase == 2 && out_ready));
         checkOutput("in_ready", 128'(in_ready), 128'(exp_ready));
         checkOutput("busy", 128'(busy), 128'(phase == 1));
         checkOutput("out_valid", 128'(out_valid), 128'(m_ov));
         checkOutput("ct", ct, m_ct);
         checkOutput("rd_state", rd_state, m_state);
         checkOutput("rd_key", rd_key, m_key);
         checkOutput("rd_rcnt", 128'(rd_rcnt), 128'(m_rcnt));
         checkOutput("rd_last", 128'(rd_last), 128'(m_last));
         if (rst) begin
            phase = 0; k_cnt = 0;
            m_state = '0; m_key = '0; m_rcnt = '0; m_last = 1'b0; m_ct = '0; m_ov = 1'b0;
         end else begin
            case (phase)
               0: if (in_valid) model_accept(pt, key);
               1: begin
                  k_cnt++;
                  if (k_cnt <= 36) begin
                     m_rcnt  = 4'(k_cnt / 4);
                     m_state = st[k_cnt / 4];
                     m_key   = ky[k_cnt / 4];
                     if (k_cnt == 36) m_last = 1'b1;
                  end else if (k_cnt == 39) begin
                     m_ct   = ct_exp;
                     m_ov   = 1'b1;
                     m_last = 1'b0;
                     phase  = 2;
                  end
               end
               default: begin
                  if (out_ready) begin
                     m_ov  = 1'b0;
                     phase = 0;
                     if (B2B && in_valid) model_accept(pt, key);
                  end
               end
            endcase
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic waitAccept();
      for (int i = 0; i < 200 && !(in_ready && in_valid); i++) @(negedge clk);
      if (!(in_ready && in_valid)) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL accept_timeout at cycle %0d: got in_ready=%0b expected 1", cyc, in_ready);
      end
   endtask

   task automatic applyStimulus(input logic [127:0] p, input logic [127:0] k, output int acc);
      pt = p;
      key = k;
      in_valid = 1'b1;
      @(negedge clk);
      waitAccept();
      @(posedge clk);
      #1;
      acc = cyc;
      in_valid = 1'b0;
      pt = rand128();
      key = rand128();
   endtask

   task automatic waitOutValid(output int c);
      for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
      if (!out_valid) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL out_valid_timeout at cycle %0d: got 0 expected 1", cyc);
      end
      c = cyc;
   endtask

   // ---------------- Test sequence ----------------
   initial begin
      int acc, c1, c2;
      for (int x = 0; x < 256; x++) sbox[x] = sbox_calc(x);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; pt = '0; key = '0;
      @(posedge clk);
      #1;
      started = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_ct", ct, 128'h0);
      checkOutput("reset_rcnt", 128'(rd_rcnt), 128'h0);

      $display("[TB] FIPS-197 C.1 vector");
      aes_mode = 1'b1;
      applyStimulus(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, acc);
      checkOutput("model_fips", ct_exp, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      waitOutValid(c1);
      checkOutput("fips_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      checkOutput("fips_latency", 128'(c1 - acc), 128'd39);
      @(posedge clk); #1;

      $display("[TB] stub datapath");
      aes_mode = 1'b0;
      applyStimulus(128'h0, 128'h0, acc);
      waitOutValid(c1);
      checkOutput("stub_ct_zero", ct, 128'h8);
      @(posedge clk); #1;
      applyStimulus(128'h1, 128'h3, acc);
      waitOutValid(c1);
      checkOutput("stub_ct_small", ct, 128'h9);
      @(posedge clk); #1;

      $display("[TB] output backpressure");
      aes_mode = 1'b1;
      out_ready = 1'b0;
      applyStimulus(rand128(), rand128(), acc);
      waitOutValid(c1);
      in_valid = 1'b1;
      pt = rand128();
      repeat (5) begin
         @(posedge clk); #1;
         pt = rand128();
      end
      checkOutput("ov_hold", 128'(out_valid), 128'h1);
      checkOutput("no_accept_in_done", 128'(in_ready), 128'h0);
      out_ready = 1'b1;
      @(negedge clk);
      waitAccept();
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitOutValid(c2);
      @(posedge clk); #1;

      $display("[TB] reset mid-block");
      applyStimulus(rand128(), rand128(), acc);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_ov", 128'(out_valid), 128'h0);
      checkOutput("rst_state", rd_state, 128'h0);
      repeat (50) @(posedge clk);
      #1;
      applyStimulus(rand128(), rand128(), acc);
      waitOutValid(c1);
      @(posedge clk); #1;

      $display("[TB] inputs while busy");
      applyStimulus(rand128(), rand128(), acc);
      repeat (20) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom_range(0, 1));
         pt = rand128();
         key = rand128();
      end
      in_valid = 1'b0;
      waitOutValid(c1);
      @(posedge clk); #1;

      $display("[TB] consecutive blocks");
      applyStimulus(rand128(), rand128(), acc);
      pt = rand128();
      key = rand128();
      in_valid = 1'b1;
      waitOutValid(c1);
      waitAccept();
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitOutValid(c2);
      checkOutput("block_gap", 128'(c2 - c1), B2B ? 128'd40 : 128'd41);
      @(posedge clk); #1;

      $display("[TB] random blocks");
      for (int b = 0; b < 6; b++) begin
         aes_mode = 1'($urandom_range(0, 1));
         out_ready = 1'b0;
         applyStimulus(rand128(), rand128(), acc);
         waitOutValid(c1);
         for (int i = 0; i < 50 && out_valid; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
